// File: rtl/mux2a1_recomb_l2_pkg.sv
// mux_l2_pkg: shared constants and lane-id type for the two-lane recombiner
package mux_l2_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  typedef logic lane_t;
  localparam lane_t LANE0 = 1'b0;
  localparam lane_t LANE1 = 1'b1;
endpackage

// File: rtl/mux2a1_recomb_l2_if.sv
// mux2a1_recomb_l2_if: lane inputs, per-lane status and recombined output bundle
interface mux2a1_recomb_l2_if import mux_l2_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic valid_in0, valid_in1, ready0, ready1, valid_out, overflow0, overflow1;
  logic [WIDTH-1:0] data_in0, data_in1, data_out;
  lane_t lane_out;
  modport master(output valid_in0, data_in0, valid_in1, data_in1,
                 input ready0, ready1, valid_out, data_out, lane_out, overflow0, overflow1);
  modport slave(input valid_in0, data_in0, valid_in1, data_in1,
                output ready0, ready1, valid_out, data_out, lane_out, overflow0, overflow1);
endinterface

// File: rtl/mux2a1_recomb_l2_fifo.sv
// fifo_lane_l2: per-lane FIFO with registered count; pushes while full are ignored
module fifo_lane_l2 import mux_l2_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr;
  // count never exceeds DEPTH, so its top bit alone marks full
  assign ready = ~count[AW];
  assign wr = push & ready;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!reset && wr) mem[wp] <= din;
endmodule

// File: rtl/mux2a1_recomb_l2.sv
// mux2a1_recomb_l2: buffers two lanes and recombines them onto one stream, round-robin on ties
module mux2a1_recomb_l2 import mux_l2_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic reset,
  mux2a1_recomb_l2_if.slave bus
);
  logic [WIDTH-1:0] dout0, dout1;
  logic [$clog2(DEPTH):0] count0, count1;
  logic elig0, elig1, any, pop0, pop1;
  lane_t g, rr_last;
  fifo_lane_l2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk(clk), .reset(reset), .push(bus.valid_in0), .din(bus.data_in0),
    .pop(pop0), .dout(dout0), .count(count0), .ready(bus.ready0)
  );
  fifo_lane_l2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk(clk), .reset(reset), .push(bus.valid_in1), .din(bus.data_in1),
    .pop(pop1), .dout(dout1), .count(count1), .ready(bus.ready1)
  );
  always_comb begin
    elig0 = count0 != '0;
    elig1 = count1 != '0;
    any = elig0 | elig1;
    g = (elig0 && elig1) ? ~rr_last : (elig1 ? LANE1 : LANE0);
    pop0 = any && g == LANE0;
    pop1 = any && g == LANE1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_out <= 1'b0;
      bus.data_out <= '0;
      bus.lane_out <= LANE0;
      bus.overflow0 <= 1'b0;
      bus.overflow1 <= 1'b0;
      rr_last <= LANE1;
    end else begin
      bus.valid_out <= any;
      bus.overflow0 <= bus.overflow0 | (bus.valid_in0 & ~bus.ready0);
      bus.overflow1 <= bus.overflow1 | (bus.valid_in1 & ~bus.ready1);
      if (any) begin
        bus.data_out <= (g == LANE1) ? dout1 : dout0;
        bus.lane_out <= g;
        rr_last <= g;
      end
    end
  end
endmodule
